bcd_countdown_disp: RTL and testbench



---
 rtl/bcd_countdown_disp.sv | 244 ++++++++++++++++++++++++
 tb/tb_bcd_countdown_disp.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_disp.sv
// bcd_countdown_disp: N-digit BCD countdown timer with run/pause/defuse/expire
// tracking and a multiplexed 7-segment scan driver, all on the clk domain.
module bcd_countdown_disp #(
    parameter int          DIGITS   = 2,
    parameter int          TICK_DIV = 1000,
    parameter int          SCAN_DIV = 4,
    parameter logic [31:0] INIT_BCD = 32'h0000_0020
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                pause,
    input  logic                success,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [7:0]          cat,
    output logic [7:0]          seg,
    output logic [4*DIGITS-1:0] count_bcd,
    output logic                running,
    output logic                expired,
    output logic                defused
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] S_MAX = SW'(SCAN_DIV - 1);
    localparam logic [2:0]    I_MAX = 3'(DIGITS - 1);
    localparam logic [W-1:0]  INIT  = INIT_BCD[W-1:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_DEFUSED,
        S_EXPIRED
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_count;
    logic [W-1:0]    r_start;
    logic [PW-1:0]   r_pre;
    logic            r_blink;
    logic [SW-1:0]   r_spre;
    logic [2:0]      r_idx;
    logic [7:0]      r_cat;
    logic [7:0]      r_seg;
    logic            r_running;
    logic            r_expired;
    logic            r_defused;

    state_t          w_state_n;
    logic [W-1:0]    w_count_n;
    logic [W-1:0]    w_start_n;
    logic [PW-1:0]   w_pre_n;
    logic            w_blink_n;
    logic [SW-1:0]   w_spre_n;
    logic [2:0]      w_idx_n;
    logic [7:0]      w_cat_n;
    logic [7:0]      w_seg_n;
    logic            w_tick;
    logic [PW-1:0]   w_pre_inc;
    logic [W-1:0]    w_dec;
    logic [W-1:0]    w_load_c;

    function automatic logic [W-1:0] f_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Borrow ripples upward; the top digit saturates at 0 instead of wrapping.
    function automatic logic [W-1:0] f_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = (i == DIGITS - 1) ? 4'd0 : 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] f_nib(input logic [W-1:0] v,
                                         input logic [2:0] idx);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == 3'(i)) n = v[4*i +: 4];
        end
        return n;
    endfunction

    function automatic logic [7:0] f_seg(input logic [3:0] n);
        logic [7:0] s;
        unique case (n)
            4'd0:    s = 8'h3F;
            4'd1:    s = 8'h06;
            4'd2:    s = 8'h5B;
            4'd3:    s = 8'h4F;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'h6D;
            4'd6:    s = 8'h7D;
            4'd7:    s = 8'h07;
            4'd8:    s = 8'h7F;
            4'd9:    s = 8'h6F;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    assign w_tick    = (r_pre == P_MAX);
    assign w_pre_inc = w_tick ? '0 : r_pre + 1'b1;
    assign w_dec     = f_dec(r_count);
    assign w_load_c  = f_clamp(load_val);

    // Game state, count and tick prescaler next-state
    always_comb begin
        w_state_n = r_state;
        w_count_n = r_count;
        w_start_n = r_start;
        w_pre_n   = r_pre;
        w_blink_n = r_blink;
        if (r_state != S_IDLE && !start) begin
            w_state_n = S_IDLE;
            w_count_n = r_start;
            w_pre_n   = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_n = (r_count == '0) ? S_EXPIRED : S_RUN;
                        w_blink_n = 1'b0;
                    end else if (load) begin
                        w_start_n = w_load_c;
                        w_count_n = w_load_c;
                    end
                end
                S_RUN: begin
                    if (success) begin
                        w_state_n = S_DEFUSED;
                    end else if (pause) begin
                        w_state_n = S_PAUSED;
                    end else begin
                        w_pre_n = w_pre_inc;
                        if (w_tick) begin
                            w_count_n = w_dec;
                            if (w_dec == '0) begin
                                w_state_n = S_EXPIRED;
                                w_blink_n = 1'b0;
                            end
                        end
                    end
                end
                S_PAUSED: begin
                    if (success)     w_state_n = S_DEFUSED;
                    else if (!pause) w_state_n = S_RUN;
                end
                S_DEFUSED: begin
                end
                S_EXPIRED: begin
                    w_pre_n = w_pre_inc;
                    if (w_tick) w_blink_n = ~r_blink;
                end
                default: w_state_n = S_IDLE;
            endcase
        end
    end

    // Scan index and registered display value, derived from next state
    always_comb begin
        w_spre_n = r_spre;
        w_idx_n  = r_idx;
        w_cat_n  = 8'hFF;
        w_seg_n  = 8'h00;
        if (w_state_n == S_IDLE) begin
            w_spre_n = '0;
            w_idx_n  = 3'd0;
        end else if (r_state != S_IDLE) begin
            if (r_spre == S_MAX) begin
                w_spre_n = '0;
                w_idx_n  = (r_idx == I_MAX) ? 3'd0 : r_idx + 3'd1;
            end else begin
                w_spre_n = r_spre + 1'b1;
            end
        end
        if (w_state_n != S_IDLE &&
            !(w_state_n == S_EXPIRED && w_blink_n)) begin
            w_cat_n = ~(8'd1 << w_idx_n);
            w_seg_n = f_seg(f_nib(w_count_n, w_idx_n));
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_count   <= INIT;
            r_start   <= INIT;
            r_pre     <= '0;
            r_blink   <= 1'b0;
            r_spre    <= '0;
            r_idx     <= 3'd0;
            r_cat     <= 8'hFF;
            r_seg     <= 8'h00;
            r_running <= 1'b0;
            r_expired <= 1'b0;
            r_defused <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_count   <= w_count_n;
            r_start   <= w_start_n;
            r_pre     <= w_pre_n;
            r_blink   <= w_blink_n;
            r_spre    <= w_spre_n;
            r_idx     <= w_idx_n;
            r_cat     <= w_cat_n;
            r_seg     <= w_seg_n;
            r_running <= (w_state_n == S_RUN);
            r_expired <= (w_state_n == S_EXPIRED);
            r_defused <= (w_state_n == S_DEFUSED);
        end
    end

    assign cat       = r_cat;
    assign seg       = r_seg;
    assign count_bcd = r_count;
    assign running   = r_running;
    assign expired   = r_expired;
    assign defused   = r_defused;

endmodule

// File: tb/tb_bcd_countdown_disp.sv
// tb_bcd_countdown_disp: randomized and directed checks of the countdown
// timer against a decimal, cycle-counting reference model.
module tb_bcd_countdown_disp;

    localparam int DG = 2;
    localparam int TD = 4;
    localparam int SD = 2;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DEF   = 3;
    localparam int M_EXP   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       success = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [7:0] cat;
    logic [7:0] seg;
    logic [7:0] count_bcd;
    logic       running;
    logic       expired;
    logic       defused;

    int tests = 0;
    int fails = 0;

    int m_mode, m_sv, m_cnt, m_acc, m_scan, m_expn;

    logic [7:0] seg_lut [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    bcd_countdown_disp #(
        .DIGITS  (DG),
        .TICK_DIV(TD),
        .SCAN_DIV(SD),
        .INIT_BCD(32'h0000_0020)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pause    (pause),
        .success  (success),
        .load     (load),
        .load_val (load_val),
        .cat      (cat),
        .seg      (seg),
        .count_bcd(count_bcd),
        .running  (running),
        .expired  (expired),
        .defused  (defused)
    );

    always #5 clk = ~clk;

    function automatic int p10(input int i);
        int r = 1;
        for (int k = 0; k < i; k++) r = r * 10;
        return r;
    endfunction

    function automatic int clamp_val(input logic [7:0] v);
        int r = 0;
        for (int i = 0; i < DG; i++) begin
            int d;
            d = int'(v[4*i +: 4]);
            if (d > 9) d = 9;
            r = r + d * p10(i);
        end
        return r;
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        logic [7:0] r = 8'h00;
        for (int i = 0; i < DG; i++) r[4*i +: 4] = 4'((n / p10(i)) % 10);
        return r;
    endfunction

    function automatic logic [15:0] exp_disp();
        int idx;
        int dig;
        logic [7:0] c;
        idx = (m_scan / SD) % DG;
        if (m_mode == M_IDLE || (m_mode == M_EXP && ((m_expn / TD) % 2) == 1))
            return {8'hFF, 8'h00};
        dig = (m_cnt / p10(idx)) % 10;
        c = 8'hFF ^ (8'd1 << idx);
        return {c, seg_lut[dig]};
    endfunction

    function automatic logic [2:0] exp_flags();
        return {m_mode == M_RUN, m_mode == M_EXP, m_mode == M_DEF};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_sv   = 20;
        m_cnt  = 20;
        m_acc  = 0;
        m_scan = 0;
        m_expn = 0;
    endtask

    task automatic model_step();
        int old;
        old = m_mode;
        if (m_mode != M_IDLE && !start) begin
            m_mode = M_IDLE;
            m_cnt  = m_sv;
            m_acc  = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (start) begin
                        m_mode = (m_cnt == 0) ? M_EXP : M_RUN;
                        m_expn = 0;
                    end else if (load) begin
                        m_sv  = clamp_val(load_val);
                        m_cnt = m_sv;
                    end
                end
                M_RUN: begin
                    if (success) m_mode = M_DEF;
                    else if (pause) m_mode = M_PAUSE;
                    else begin
                        m_acc++;
                        if (m_acc == TD) begin
                            m_acc = 0;
                            m_cnt--;
                            if (m_cnt == 0) begin
                                m_mode = M_EXP;
                                m_expn = 0;
                            end
                        end
                    end
                end
                M_PAUSE: begin
                    if (success) m_mode = M_DEF;
                    else if (!pause) m_mode = M_RUN;
                end
                M_EXP: m_expn++;
                default: ;
            endcase
        end
        if (m_mode == M_IDLE || old == M_IDLE) m_scan = 0;
        else m_scan++;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (cat !== 8'hFF) begin
            fails++; $display("FAIL reset_cat got %h want FF", cat);
        end
        tests++;
        if (seg !== 8'h00) begin
            fails++; $display("FAIL reset_seg got %h want 00", seg);
        end
        tests++;
        if (count_bcd !== 8'h20) begin
            fails++; $display("FAIL reset_cnt got %h want 20", count_bcd);
        end
        tests++;
        if ({running, expired, defused} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags got %b want 000", {running, expired, defused});
        end
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_countdown();
        start = 1'b1;
        cyc();
        tests++;
        if (running !== 1'b1) begin
            fails++; $display("FAIL cd_running got %b want 1", running);
        end
        for (int k = 1; k <= 80; k++) begin
            cyc();
            tests++;
            if ({cat, seg} !== exp_disp() || count_bcd !== to_bcd(m_cnt) ||
                {running, expired, defused} !== exp_flags()) begin
                fails++;
                $display("FAIL cd_cyc%0d got %h %h %h %b want %h %h %b", k,
                         cat, seg, count_bcd, {running, expired, defused},
                         exp_disp(), to_bcd(m_cnt), exp_flags());
            end
            if (k == 4) begin
                tests++;
                if (count_bcd !== 8'h19) begin
                    fails++; $display("FAIL cd_borrow got %h want 19", count_bcd);
                end
            end
        end
        tests++;
        if (count_bcd !== 8'h00 || expired !== 1'b1 || running !== 1'b0) begin
            fails++;
            $display("FAIL cd_end got %h e%b r%b want 00 e1 r0",
                     count_bcd, expired, running);
        end
        start = 1'b0;
        cyc();
        tests++;
        if (count_bcd !== 8'h20 || cat !== 8'hFF) begin
            fails++; $display("FAIL cd_abort got %h %h want 20 FF", count_bcd, cat);
        end
    endtask

    task automatic test_pause();
        start = 1'b1;
        repeat (3) cyc();
        pause = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            tests++;
            if (count_bcd !== 8'h20 || running !== 1'b0 ||
                {cat, seg} !== exp_disp()) begin
                fails++;
                $display("FAIL pause_hold%0d got %h r%b %h%h want 20 r0 %h",
                         k, count_bcd, running, cat, seg, exp_disp());
            end
        end
        pause = 1'b0;
        cyc();
        cyc();
        tests++;
        if (count_bcd !== 8'h20 || running !== 1'b1) begin
            fails++; $display("FAIL pause_resume got %h want 20", count_bcd);
        end
        cyc();
        tests++;
        if (count_bcd !== 8'h19 || count_bcd !== to_bcd(m_cnt)) begin
            fails++; $display("FAIL pause_tick got %h want 19", count_bcd);
        end
        start = 1'b0;
        cyc();
    endtask

    task automatic test_defuse();
        bit found = 0;
        start = 1'b1;
        for (int k = 0; k < 400 && !found; k++) begin
            cyc();
            if (m_cnt == 13 && m_acc == TD - 1) found = 1;
        end
        tests++;
        if (!found || count_bcd !== 8'h13) begin
            fails++; $display("FAIL def_reach got %h want 13", count_bcd);
        end
        success = 1'b1;
        cyc();
        tests++;
        if (defused !== 1'b1 || count_bcd !== 8'h13) begin
            fails++; $display("FAIL def_tick got d%b %h want d1 13", defused, count_bcd);
        end
        for (int k = 0; k < 12; k++) begin
            success = k[0];
            pause = k[1];
            cyc();
            tests++;
            if (count_bcd !== 8'h13 || defused !== 1'b1 ||
                {cat, seg} !== exp_disp()) begin
                fails++;
                $display("FAIL def_hold%0d got %h d%b %h%h want 13 d1 %h",
                         k, count_bcd, defused, cat, seg, exp_disp());
            end
        end
        success = 1'b0;
        pause = 1'b0;
        start = 1'b0;
        cyc();
        tests++;
        if (count_bcd !== 8'h20 || cat !== 8'hFF || defused !== 1'b0) begin
            fails++; $display("FAIL def_abort got %h %h want 20 FF", count_bcd, cat);
        end
    endtask

    task automatic test_load();
        load = 1'b1;
        load_val = 8'h3A;
        cyc();
        load = 1'b0;
        tests++;
        if (count_bcd !== 8'h39) begin
            fails++; $display("FAIL load_clamp got %h want 39", count_bcd);
        end
        start = 1'b1;
        cyc();
        load = 1'b1;
        load_val = 8'($urandom_range(0, 255));
        cyc();
        load = 1'b0;
        tests++;
        if (count_bcd !== 8'h39 || count_bcd !== to_bcd(m_cnt)) begin
            fails++; $display("FAIL load_run got %h want 39", count_bcd);
        end
        start = 1'b0;
        cyc();
        tests++;
        if (count_bcd !== 8'h39) begin
            fails++; $display("FAIL load_keep got %h want 39", count_bcd);
        end
    endtask

    task automatic test_zero_start();
        logic [7:0] ec;
        logic [7:0] es;
        bit         blank;
        load = 1'b1;
        load_val = 8'h00;
        cyc();
        load = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 16; k++) begin
            cyc();
            blank = ((k / 4) % 2) == 1;
            ec = blank ? 8'hFF : ((((k / 2) % 2) == 1) ? 8'hFD : 8'hFE);
            es = blank ? 8'h00 : 8'h3F;
            tests++;
            if (expired !== 1'b1 || running !== 1'b0 ||
                cat !== ec || seg !== es || count_bcd !== 8'h00) begin
                fails++;
                $display("FAIL zero_blink%0d got e%b r%b %h %h want e1 r0 %h %h",
                         k, expired, running, cat, seg, ec, es);
            end
        end
        start = 1'b0;
        cyc();
    endtask

    task automatic test_scan_rst();
        logic [7:0] ec;
        logic [7:0] es;
        load = 1'b1;
        load_val = 8'h17;
        cyc();
        load = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            ec = (((k / 2) % 2) == 1) ? 8'hFD : 8'hFE;
            es = (((k / 2) % 2) == 1) ? 8'h06 : 8'h07;
            tests++;
            if (cat !== ec || seg !== es || cat[7:2] !== 6'h3F) begin
                fails++;
                $display("FAIL scan%0d got %h %h want %h %h", k, cat, seg, ec, es);
            end
        end
        #2 rst = 1'b0;
        #1;
        model_reset();
        tests++;
        if (cat !== 8'hFF || seg !== 8'h00 || count_bcd !== 8'h20 ||
            running !== 1'b0) begin
            fails++;
            $display("FAIL async_rst got %h %h %h r%b want FF 00 20 r0",
                     cat, seg, count_bcd, running);
        end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            start    = ($urandom_range(0, 39) != 0);
            pause    = ($urandom_range(0, 4) == 0);
            success  = ($urandom_range(0, 59) == 0);
            load     = ($urandom_range(0, 2) == 0);
            load_val = 8'($urandom_range(0, 255));
            if (k % 150 < 3) begin
                start = 1'b0;
                load_val = 8'($urandom_range(0, 5));
            end
            cyc();
            tests++;
            if ({cat, seg} !== exp_disp() || count_bcd !== to_bcd(m_cnt) ||
                {running, expired, defused} !== exp_flags()) begin
                fails++;
                $display("FAIL rand%0d got %h %h %h %b want %h %h %b", k,
                         cat, seg, count_bcd, {running, expired, defused},
                         exp_disp(), to_bcd(m_cnt), exp_flags());
            end
        end
        start = 1'b0;
        pause = 1'b0;
        success = 1'b0;
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_pause();
        test_defuse();
        test_load();
        test_zero_start();
        test_scan_rst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
